// File: rtl/tlc_detector_pkg.sv
// Shared defaults and FAULT bit positions for the vehicle-detector front end.
package tlc_detector_pkg;

    localparam int DEF_DEB_CYC   = 4;
    localparam int DEF_STUCK_CYC = 1024;
    localparam int DEF_CW        = 4;

    localparam int SIDE = 0;
    localparam int TURN = 1;
    localparam int NUM_CH = 2;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tlc_det_channel.sv
// One detector channel: synchroniser, debounce, call latch, wait counter and
// stuck-sensor watchdog.
module tlc_det_channel
    import tlc_detector_pkg::*;
#(
    parameter int DEB_CYC   = DEF_DEB_CYC,
    parameter int STUCK_CYC = DEF_STUCK_CYC,
    parameter int CW        = DEF_CW
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          raw,
    input  logic          svc,
    output logic          call,
    output logic [CW-1:0] wait_cnt,
    output logic          fault
);

    localparam int DW = cnt_width(DEB_CYC);
    localparam int SW = cnt_width(STUCK_CYC);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYC);
    localparam logic [SW-1:0] STUCK_PRE = SW'(STUCK_CYC - 1);
    localparam logic [CW-1:0] WAIT_MAX  = '1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q, filt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic          fault_q, fault_d;
    logic          call_q, call_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          rise;

    always_comb begin
        sync1_d     = raw;
        sync2_d     = sync1_q;
        filt_d      = filt_q;
        deb_cnt_d   = '0;
        stuck_cnt_d = '0;
        fault_d     = fault_q;
        call_d      = call_q;
        wait_d      = wait_q;

        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        rise = filt_d & ~filt_q;

        // Once the limit is reached the counter parks there; FAULT is sticky.
        if (filt_q) begin
            if (stuck_cnt_q == STUCK_MAX) begin
                stuck_cnt_d = stuck_cnt_q;
            end else if (stuck_cnt_q == STUCK_PRE) begin
                stuck_cnt_d = STUCK_MAX;
                fault_d     = 1'b1;
            end else begin
                stuck_cnt_d = stuck_cnt_q + 1'b1;
            end
        end

        if (fault_d) begin
            call_d = 1'b1;
        end else if (rise) begin
            call_d = 1'b1;
        end else if (svc) begin
            call_d = 1'b0;
        end

        if (svc) begin
            wait_d    = '0;
            wait_d[0] = rise;
        end else if (rise && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            deb_cnt_q   <= '0;
            stuck_cnt_q <= '0;
            fault_q     <= 1'b0;
            call_q      <= 1'b0;
            wait_q      <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            deb_cnt_q   <= deb_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            fault_q     <= fault_d;
            call_q      <= call_d;
            wait_q      <= wait_d;
        end
    end

    assign call     = call_q;
    assign wait_cnt = wait_q;
    assign fault    = fault_q;

endmodule

// File: rtl/tlc_detector.sv
// Detector front end: side-street and main-turn channels feeding SD/MD calls
// to the traffic light controller.
module tlc_detector
    import tlc_detector_pkg::*;
#(
    parameter int DEB_CYC   = DEF_DEB_CYC,
    parameter int STUCK_CYC = DEF_STUCK_CYC,
    parameter int CW        = DEF_CW
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          SD_RAW,
    input  logic          MD_RAW,
    input  logic          SG,
    input  logic          MA,
    output logic          SD,
    output logic          MD,
    output logic [CW-1:0] S_WAIT,
    output logic [CW-1:0] M_WAIT,
    output logic [1:0]    FAULT
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] svc_vec;
    logic [NUM_CH-1:0] call_vec;
    logic [NUM_CH-1:0] fault_vec;
    logic [CW-1:0]     wait_vec [NUM_CH];

    assign raw_vec[SIDE] = SD_RAW;
    assign raw_vec[TURN] = MD_RAW;
    assign svc_vec[SIDE] = SG;
    assign svc_vec[TURN] = MA;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            tlc_det_channel #(
                .DEB_CYC   (DEB_CYC),
                .STUCK_CYC (STUCK_CYC),
                .CW        (CW)
            ) u_ch (
                .clk      (CLK),
                .srst     (CLR),
                .raw      (raw_vec[gi]),
                .svc      (svc_vec[gi]),
                .call     (call_vec[gi]),
                .wait_cnt (wait_vec[gi]),
                .fault    (fault_vec[gi])
            );
        end
    endgenerate

    assign SD     = call_vec[SIDE];
    assign MD     = call_vec[TURN];
    assign S_WAIT = wait_vec[SIDE];
    assign M_WAIT = wait_vec[TURN];
    assign FAULT  = fault_vec;

endmodule

// File: tb/tb_tlc_detector.sv
// Randomised and directed bench for tlc_detector against a window-based model.
module tb_tlc_detector;

    localparam int DEB   = 4;
    localparam int STUCK = 16;
    localparam int CWB   = 4;
    localparam int WMAX  = (1 << CWB) - 1;
    localparam int MAXC  = 4096;

    logic           CLK, CLR, SD_RAW, MD_RAW, SG, MA;
    logic           SD, MD;
    logic [CWB-1:0] S_WAIT, M_WAIT;
    logic [1:0]     FAULT;

    tlc_detector #(.DEB_CYC(DEB), .STUCK_CYC(STUCK), .CW(CWB)) dut (
        .CLK(CLK), .CLR(CLR), .SD_RAW(SD_RAW), .MD_RAW(MD_RAW),
        .SG(SG), .MA(MA), .SD(SD), .MD(MD),
        .S_WAIT(S_WAIT), .M_WAIT(M_WAIT), .FAULT(FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    bit raw_h [2][MAXC];
    bit clr_h [MAXC];

    bit m_filt [2];
    bit m_call [2];
    bit m_fault[2];
    int m_wait [2];
    int m_hr   [2];
    int m_ltog [2];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d edge=%0d", tag, got, exp, t);
        end
    endtask

    // Level the debouncer sees at edge tt: raw two edges earlier, zeroed by a recent CLR.
    function automatic bit dsamp(input int c, input int tt);
        if (tt < 2) return 1'b0;
        if (clr_h[tt-1] || clr_h[tt-2]) return 1'b0;
        return raw_h[c][tt-2];
    endfunction

    task automatic model_edge(input int tt, input bit svc0, input bit svc1);
        bit tog, rise, svc;
        for (int c = 0; c < 2; c++) begin
            svc = (c == 0) ? svc0 : svc1;
            if (clr_h[tt]) begin
                m_filt[c] = 0; m_call[c] = 0; m_fault[c] = 0;
                m_wait[c] = 0; m_hr[c] = 0; m_ltog[c] = tt;
            end else begin
                // Filter flips once the last DEB seen levels all disagree with it.
                tog = (tt - m_ltog[c] >= DEB);
                for (int k = tt - DEB + 1; k <= tt; k++)
                    if (tog && dsamp(c, k) == m_filt[c]) tog = 0;
                rise = tog && !m_filt[c];
                if (m_filt[c]) begin
                    m_hr[c]++;
                    if (m_hr[c] >= STUCK) m_fault[c] = 1;
                end else begin
                    m_hr[c] = 0;
                end
                if (m_fault[c] || rise) m_call[c] = 1;
                else if (svc)           m_call[c] = 0;
                if (svc) m_wait[c] = rise ? 1 : 0;
                else if (rise && m_wait[c] < WMAX) m_wait[c]++;
                if (tog) begin
                    m_filt[c] = !m_filt[c];
                    m_ltog[c] = tt;
                end
            end
        end
    endtask

    task automatic drive(input int n, input bit clr, input bit sr, input bit mr,
                         input bit sg, input bit ma);
        for (int i = 0; i < n; i++) begin
            CLR = clr; SD_RAW = sr; MD_RAW = mr; SG = sg; MA = ma;
            @(posedge CLK);
            clr_h[t] = clr; raw_h[0][t] = sr; raw_h[1][t] = mr;
            model_edge(t, sg, ma);
            t++;
            #1;
            check("sd", int'(SD), int'(m_call[0]));
            check("md", int'(MD), int'(m_call[1]));
            check("s_wait", int'(S_WAIT), m_wait[0]);
            check("m_wait", int'(M_WAIT), m_wait[1]);
            check("fault", int'(FAULT), int'({m_fault[1], m_fault[0]}));
        end
    endtask

    initial begin
        int hold[2];
        bit lvl[2];
        CLR = 1; SD_RAW = 0; MD_RAW = 0; SG = 0; MA = 0;
        for (int c = 0; c < 2; c++) begin
            m_filt[c] = 0; m_call[c] = 0; m_fault[c] = 0;
            m_wait[c] = 0; m_hr[c] = 0; m_ltog[c] = 0;
        end

        // Reset with detectors active, then latency from CLR release.
        drive(2, 1, 1, 1, 0, 0);
        check("rst_outputs", int'({SD, MD, S_WAIT, M_WAIT, FAULT}), 0);
        drive(5, 0, 1, 1, 0, 0);
        check("sd_lat5", int'(SD), 0);
        drive(1, 0, 1, 1, 0, 0);
        check("sd_lat6", int'(SD), 1);
        drive(12, 0, 0, 0, 0, 0);
        drive(2, 1, 0, 0, 0, 0);
        $display("phase reset/latency edge=%0d", t);

        // Glitch rejection vs minimum accepted pulse.
        drive(3, 0, 1, 0, 0, 0);
        drive(10, 0, 0, 0, 0, 0);
        check("glitch_sd", int'(SD), 0);
        check("glitch_wait", int'(S_WAIT), 0);
        drive(4, 0, 1, 0, 0, 0);
        drive(10, 0, 0, 0, 0, 0);
        check("pulse4_sd", int'(SD), 1);
        check("pulse4_wait", int'(S_WAIT), 1);
        drive(2, 1, 0, 0, 0, 0);
        $display("phase debounce edge=%0d", t);

        // Turn arrivals, service, and arrival coincident with service.
        for (int i = 0; i < 3; i++) begin
            drive(6, 0, 0, 1, 0, 0);
            drive(8, 0, 0, 0, 0, 0);
            check("m_wait_cnt", int'(M_WAIT), i + 1);
        end
        drive(1, 0, 0, 0, 0, 1);
        check("ma_md", int'(MD), 0);
        check("ma_wait", int'(M_WAIT), 0);
        drive(5, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 1);
        check("coinc_md", int'(MD), 1);
        check("coinc_wait", int'(M_WAIT), 1);
        drive(10, 0, 0, 0, 0, 0);
        drive(2, 1, 0, 0, 0, 0);
        $display("phase service edge=%0d", t);

        // Saturation of the side wait counter.
        for (int i = 0; i < 20; i++) begin
            drive(5, 0, 1, 0, 0, 0);
            drive(5, 0, 0, 0, 0, 0);
        end
        check("sat_wait", int'(S_WAIT), WMAX);
        drive(2, 1, 0, 0, 0, 0);
        $display("phase saturate edge=%0d", t);

        // Stuck side detector: fault, fail-safe recall, cleared only by CLR.
        drive(30, 0, 1, 0, 0, 0);
        check("stuck_fault", int'(FAULT[0]), 1);
        drive(20, 0, 0, 0, 1, 0);
        check("failsafe_sd", int'(SD), 1);
        check("fault_sticky", int'(FAULT[0]), 1);
        drive(2, 1, 0, 0, 0, 0);
        check("fault_clr", int'(FAULT), 0);
        $display("phase watchdog edge=%0d", t);

        // Both channels together, then only side serviced.
        drive(8, 0, 1, 1, 0, 0);
        drive(8, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        check("indep_sd", int'(SD), 0);
        check("indep_md", int'(MD), 1);
        check("indep_mwait", int'(M_WAIT), 1);
        $display("phase independence edge=%0d", t);

        // Random level-held stimulus.
        hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
        for (int i = 0; i < 1500 && t < MAXC - 10; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    lvl[c]  = !lvl[c];
                    hold[c] = int'($urandom_range(1, 9));
                    if ($urandom_range(0, 30) == 0) hold[c] = 20;
                end
                hold[c]--;
            end
            drive(1, $urandom_range(0, 199) == 0, lvl[0], lvl[1],
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        $display("phase random edge=%0d", t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
